// File: rtl/mem_requester.sv
// mem_requester: request/response front end for a single-port synchronous memory
// with one-cycle read latency; supports single writes, single reads and incrementing burst reads.
`default_nettype none

module mem_requester #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              mem_re_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RSP      = 3'd4
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_last_q;
  logic              wr_done_q;
  logic              mem_re_en_q;
  logic              mem_wr_en_q;
  logic [ADDR_W-1:0] mem_adrs_q;
  logic [DATA_W-1:0] mem_wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      mem_re_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_adrs_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wr_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            mem_adrs_q  <= req_addr;
            if (req_we) begin
              mem_wr_en_q <= 1'b1;
              mem_wdata_q <= req_wdata;
              state_q     <= S_WR_ISSUE;
            end else begin
              mem_re_en_q <= 1'b1;
              remaining_q <= req_len;
              state_q     <= S_RD_ISSUE;
            end
          end
        end
        S_WR_ISSUE: begin
          mem_wr_en_q <= 1'b0;
          wr_done_q   <= 1'b1;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_RD_ISSUE: begin
          // Memory samples the read enable on this edge; data is valid next cycle.
          mem_re_en_q <= 1'b0;
          state_q     <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          rsp_data_q  <= mem_rdata;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= (remaining_q == '0);
          state_q     <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            if (remaining_q == '0) begin
              req_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              remaining_q <= remaining_q - LEN_W'(1);
              mem_adrs_q  <= mem_adrs_q + ADDR_W'(1);
              mem_re_en_q <= 1'b1;
              state_q     <= S_RD_ISSUE;
            end
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_re_en_q <= 1'b0;
          mem_wr_en_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign wr_done   = wr_done_q;
  assign mem_re_en = mem_re_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_adrs  = mem_adrs_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- Initiator-side controller for the team's single-port 18-bit synchronous memory.
- Drives that memory's read-enable, write-enable, address and write-data.
- Memory read data appears on the memory's data output one clock after it samples read-enable high.
- Presents a valid/ready request/response interface to the sequencer or CPU side, with single writes, single reads and incrementing burst reads.
- Guarantees re_en and wr_en are never asserted together.

Parameters:
DATA_W, 18, memory word width
ADDR_W, 13, memory address width
LEN_W, 4, burst length field width (burst of 1..2^LEN_W words)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  start address
req_wdata  input  DATA_W  write data (writes only)
req_len  input  LEN_W  read burst length minus 1 (ignored for writes)
rsp_valid  output  1  read data valid
rsp_ready  input  1  consumer accepts read data
rsp_data  output  DATA_W  read data
rsp_last  output  1  final word of a burst (qualified by rsp_valid)
wr_done  output  1  one-cycle pulse when a write has been issued to memory
mem_re_en  output  1  to memory read enable
mem_wr_en  output  1  to memory write enable
mem_adrs  output  ADDR_W  to memory address
mem_wdata  output  DATA_W  to memory write data
mem_rdata  input  DATA_W  from memory read data output

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE. Outputs req_ready=1, rsp_valid=0, rsp_last=0, rsp_data=0, wr_done=0, mem_re_en=0, mem_wr_en=0, mem_adrs=0, mem_wdata=0. Burst counter=0.
- Reset asserted mid-operation aborts the request immediately. No response is produced, and any pending rsp_valid is dropped.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RSP.
- req_ready=1 only in IDLE. A request is accepted on a clock edge where req_valid & req_ready.
- IDLE, write accepted -> WR_ISSUE:
  - mem_wr_en=1, mem_adrs=req_addr, mem_wdata=req_wdata for exactly one cycle.
  - Then -> IDLE with wr_done=1 for one cycle; req_ready returns to 1 in that same cycle.
- IDLE, read accepted -> RD_ISSUE:
  - Latch remaining=req_len.
  - mem_re_en=1 and mem_adrs=addr for exactly one cycle.
- RD_ISSUE -> RD_WAIT: mem_re_en=0, mem_adrs held. The memory updates mem_rdata on this edge.
- RD_WAIT -> RSP: capture rsp_data=mem_rdata; rsp_valid=1; rsp_last=(remaining==0).
- Read latency: rsp_valid asserts on the 3rd rising edge after acceptance.
- RSP: rsp_valid, rsp_data and rsp_last are held stable until rsp_ready=1 (backpressure of any length). On the handshake edge:
  - if remaining==0 -> IDLE, rsp_valid=0;
  - else remaining-=1, mem_adrs+=1 (modulo 2^ADDR_W; 8191 wraps to 0), -> RD_ISSUE.
- Burst throughput: one word per 3 cycles when rsp_ready is held high.
- mem_re_en and mem_wr_en are mutually exclusive in every cycle, and both are 0 in IDLE, RD_WAIT and RSP.
- mem_wdata changes only on write acceptance. mem_adrs changes only on acceptance or burst advance.
- req_* inputs are ignored outside IDLE. A request held asserted is accepted on the first IDLE edge.
- rsp_ready is ignored when rsp_valid=0.

Test Plan:
- Reset release, no requests -> all outputs at reset values, req_ready=1, no mem_re_en/mem_wr_en pulses for 20 cycles.
- Write addr=12, data=18'h3FFFF -> exactly one cycle of mem_wr_en=1, mem_adrs=12, mem_wdata=18'h3FFFF; wr_done pulses on the following cycle; memory model holds 18'h3FFFF at 12.
- Memory reset-loaded (addr1=18'b001000000000000011); read addr=1, len=0, rsp_ready=1 -> rsp_valid on 3rd edge after acceptance, rsp_data=18'b001000000000000011, rsp_last=1, back to IDLE.
- Burst read addr=8190, len=3 -> reads of 8190, 8191, 0, 1 in order; rsp_last=1 only on the 4th word; mem_re_en never coincides with mem_wr_en.
- Read with rsp_ready=0 for 7 cycles -> rsp_valid and rsp_data held stable, no further mem_re_en until the handshake.
- rst=0 asserted during RD_WAIT of a 4-word burst -> outputs go to reset values asynchronously with no clock edge; after release a new read of addr=2 returns 18'b011000000000000001.
